// File: rtl/mips_pipe_reg_chain.sv
// mips_pipe_reg_chain: valid+payload stage registers with hold/flush and automatic bubbles; PIPE_PERF_CNT_EN adds saturating stall/flush/bubble counters
module mips_pipe_reg_chain #(
    parameter int DATA_W = 64,
    parameter int STAGES = 4
`ifdef PIPE_PERF_CNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        hold,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        out_valid,
    output logic [STAGES*DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,output logic [CNT_W-1:0]        stall_cnt
    ,output logic [CNT_W-1:0]        flush_cnt
    ,output logic [CNT_W-1:0]        bubble_cnt
`endif
);
    logic [STAGES-1:0] eh, prev_eh, prev_v, bubble, valid_q, valid_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [DATA_W-1:0] prev_d [STAGES];
    // a stage is effectively held if it or any later stage is held
    always_comb begin
        for (int i = 0; i < STAGES; i++) eh[i] = |(hold >> i);
    end
    assign in_ready = ~eh[0];
    assign prev_eh  = {eh[STAGES-2:0], 1'b0};
    assign prev_v   = {valid_q[STAGES-2:0], in_valid};
    always_comb begin
        prev_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) prev_d[i] = data_q[i-1];
    end
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            bubble[i]  = ~flush[i] & ~eh[i] & prev_eh[i];
            valid_d[i] = (flush[i] | bubble[i]) ? 1'b0 : eh[i] ? valid_q[i] : prev_v[i];
            data_d[i]  = (flush[i] | bubble[i]) ? '0 : eh[i] ? data_q[i] : prev_d[i];
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
        end
    end
    assign out_valid = valid_q;
    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
    end
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, bubble_q, stall_d, flush_d, bubble_d;
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [3:0] n);
        logic [CNT_W+3:0] s;
        s = {4'b0, c} + {{CNT_W{1'b0}}, n};
        return (|s[CNT_W+3:CNT_W]) ? '1 : s[CNT_W-1:0];
    endfunction
    always_comb begin
        stall_d  = sat_add(stall_q, {3'b0, eh[0]});
        flush_d  = sat_add(flush_q, 4'($countones(flush & valid_q)));
        bubble_d = sat_add(bubble_q, 4'($countones(bubble)));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            bubble_q <= bubble_d;
        end
    end
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_mips_pipe_reg_chain.sv
// tb_mips_pipe_reg_chain: scoreboard bench with a shift-and-freeze reference model
module tb_mips_pipe_reg_chain;
    localparam int W = 16;
    localparam int S = 4;
    localparam int CW = 4;
    typedef struct packed {
        logic [S-1:0]   v;
        logic [S*W-1:0] d;
        logic [CW-1:0]  sc;
        logic [CW-1:0]  fc;
        logic [CW-1:0]  bc;
    } exp_t;
    logic clk = 0, reset_n = 0, in_valid = 0, in_ready;
    logic [W-1:0] in_data = '0;
    logic [S-1:0] hold = '0, flush = '0, out_valid;
    logic [S*W-1:0] out_data;
    logic [CW-1:0] stall_cnt, flush_cnt, bubble_cnt;
    exp_t q[$];
    bit mv[S];
    logic [W-1:0] md[S];
    int sc, fc, bc;
    int n_checks = 0, n_fail = 0;
`ifdef PIPE_PERF_CNT_EN
    mips_pipe_reg_chain #(.DATA_W(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .bubble_cnt(bubble_cnt));
`else
    mips_pipe_reg_chain #(.DATA_W(W), .STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .flush(flush), .out_valid(out_valid),
        .out_data(out_data));
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign bubble_cnt = '0;
`endif
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_clear();
        for (int i = 0; i < S; i++) begin
            mv[i] = 0;
            md[i] = '0;
        end
        sc = 0;
        fc = 0;
        bc = 0;
    endtask
    // everything at or below the highest held stage freezes, the stage just past it gets a bubble, the rest shift
    task automatic model_step(input logic [S-1:0] h, input logic [S-1:0] f, input logic iv, input logic [W-1:0] id);
        int top, nf, nb;
        bit nv[S];
        logic [W-1:0] nd[S];
        exp_t e;
        top = -1;
        nf = 0;
        nb = 0;
        for (int i = 0; i < S; i++) if (h[i]) top = i;
        for (int i = 0; i < S; i++) begin
            if (f[i]) begin
                nv[i] = 0;
                nd[i] = '0;
                if (mv[i]) nf++;
            end else if (i <= top) begin
                nv[i] = mv[i];
                nd[i] = md[i];
            end else if (top >= 0 && i == top + 1) begin
                nv[i] = 0;
                nd[i] = '0;
                nb++;
            end else begin
                nv[i] = (i == 0) ? iv : mv[i-1];
                nd[i] = (i == 0) ? id : md[i-1];
            end
        end
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
            e.v[i] = nv[i];
            e.d[i*W +: W] = nd[i];
        end
        sc = (sc + (top >= 0 ? 1 : 0) > 15) ? 15 : sc + (top >= 0 ? 1 : 0);
        fc = (fc + nf > 15) ? 15 : fc + nf;
        bc = (bc + nb > 15) ? 15 : bc + nb;
        e.sc = CW'(sc);
        e.fc = CW'(fc);
        e.bc = CW'(bc);
        q.push_back(e);
    endtask
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic [S-1:0] h, input logic [S-1:0] f, input bit rst_pulse = 0);
        @(negedge clk);
        in_valid = iv;
        in_data = id;
        hold = h;
        flush = f;
        #1;
        check("in_ready", 64'(in_ready), 64'(h == '0));
        if (rst_pulse) begin
            reset_n = 0;
            #1;
            check("async_rst_valid", 64'(out_valid), 64'(0));
            check("async_rst_data", out_data, 64'(0));
            check("async_rst_in_ready", 64'(in_ready), 64'(h == '0));
            model_clear();
            reset_n = 1;
        end
        model_step(h, f, iv, id);
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_valid", 64'(out_valid), 64'(e.v));
                check("out_data", out_data, 64'(e.d));
`ifdef PIPE_PERF_CNT_EN
                check("stall_cnt", 64'(stall_cnt), 64'(e.sc));
                check("flush_cnt", 64'(flush_cnt), 64'(e.fc));
                check("bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
`endif
            end
        end
    end
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
    initial begin : stim
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_data", out_data, 64'(0));
        reset_n = 1;
        for (int k = 1; k <= 4; k++) cycle(1, W'(k), '0, '0);
        cycle(0, 16'h0055, 4'b0010, '0);
        for (int k = 5; k <= 8; k++) cycle(1, W'(k), '0, '0);
        cycle(1, 16'h0009, '0, 4'b0001);
        cycle(1, 16'hAAAA, 4'b0001, 4'b0001);
        cycle(1, 16'h0010, '0, '0);
        cycle(1, 16'h0011, 4'b1000, '0);
        cycle(1, 16'h0012, 4'b1000, '0);
        cycle(1, 16'h0013, 4'b1000, '0, 1);
        cycle(1, 16'h0014, '0, 4'b0100);
        for (int k = 0; k < 20; k++) cycle(1, W'($urandom), 4'b0001, '0);
`ifdef PIPE_PERF_CNT_EN
        @(posedge clk);
        #2;
        check("stall_sat", 64'(stall_cnt), 64'(4'hF));
`endif
        for (int k = 0; k < 400; k++) begin
            logic [S-1:0] h, f;
            for (int b = 0; b < S; b++) begin
                h[b] = ($urandom_range(0, 7) == 0);
                f[b] = ($urandom_range(0, 9) == 0);
            end
            cycle(1'($urandom), W'($urandom), h, f, $urandom_range(0, 149) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
